projectile_pool: RTL and testbench
==================================

# projectile_pool

Parametrised projectile engine for the two-player fighter. It replaces the single-ball-per-player cannon with SLOTS independent projectiles per player. Each player has a fire cooldown, and the block does off-screen retirement, hit/block detection against the opponent hitbox, and projectile-vs-projectile cancellation. It sits between the player movement blocks, which supply muzzle positions, facing, hitboxes and block state, and the color mapper, which consumes the packed ball positions, active flags and hit/block/clash pulses.

## Interface
- SLOTS, 4, projectiles per player (1..8)
- SPEED, 4, pixels moved per frame
- COOLDOWN, 16, frames between spawns for one player
- BALL_SIZE, 8, projectile square edge in pixels
- X_MAX, 639, rightmost visible pixel column
- BOX_W, 48, hitbox width; BOX_H, 96, hitbox height
- Clk  in  1  system clock (MAX10_CLK1_50)
- Reset  in  1  synchronous, active-high
- frame_tick  in  1  one-Clk pulse per frame (VS edge, generated upstream)
- start  in  1  game running; low clears and freezes the pool
- fire  in  2  per-player fire request, level, sampled on frame_tick
- facing  in  2  per-player direction: 0 = right, 1 = left
- spawn_x, spawn_y  in  20 each  muzzle position, player p at [p*10 +: 10]
- box_x, box_y  in  20 each  hitbox top-left, player p at [p*10 +: 10]
- blocking  in  2  player p is blocking
- ball_x, ball_y  out  2*SLOTS*10  slot (p,s) at [(p*SLOTS+s)*10 +: 10]; 0 when inactive
- ball_active  out  2*SLOTS  bit p*SLOTS+s
- hit  out  2  player p's projectile struck the unblocking opponent this frame
- blocked  out  2  player p's projectile struck the blocking opponent this frame
- clash  out  1  at least one opposing pair cancelled this frame

## Operation
- Per-slot state: active, dir, x[9:0], y[9:0]. Per-player state: cooldown counter, width clog2(COOLDOWN+1).
- All work happens on a frame_tick cycle with start=1. Every step below evaluates against the pre-tick state.
- Move: each active slot does x ± SPEED, with dir 0 = +, 1 = −.
- Off-screen retire:
  - dir=1 with x < SPEED retires.
  - dir=0 with x + SPEED > X_MAX + 1 − BALL_SIZE retires.
  - The compare uses 11-bit arithmetic, so x never wraps.
- Clash:
  - Every surviving P0 slot is compared with every surviving P1 slot.
  - The pair overlaps if the moved BALL_SIZE squares overlap on both axes, using inclusive bounds.
  - Each slot that overlaps any opposing slot retires, and clash pulses.
- Hit:
  - A surviving slot of player p overlaps the box of player 1−p: [box_x, box_x+BOX_W−1] × [box_y, box_y+BOX_H−1].
  - The slot retires.
  - hit[p] pulses if blocking[1−p]=0; otherwise blocked[p] pulses.
  - Multiple simultaneous hits produce one pulse.
- Priority per slot: off-screen > clash > hit.
- Cooldown: if >0, it decrements by 1 per tick.
- Spawn:
  - Condition: fire[p]=1, pre-tick cooldown[p]=0, and a slot of p is free.
  - A free slot is one that was inactive pre-tick. Slots retiring this tick are not reusable until the next tick.
  - The lowest-index free slot takes spawn_x/spawn_y and dir=facing[p], and cooldown[p] loads COOLDOWN.
  - A spawned slot is not moved or collision-checked in its spawn tick.
  - With no free slot, the request is dropped and cooldown stays 0.
- Retired slots force x=y=0.
- start=0: all slots go inactive with zero positions, cooldowns clear, pulses stay 0, and ticks are ignored.

## Timing
- Reset value of every output and internal register: 0.
- Reset wins over frame_tick and start in the same cycle.
- Latency: positions, ball_active, hit, blocked and clash are registered. They update on the Clk edge that samples frame_tick and are visible the following cycle.
- hit, blocked and clash are high for exactly one Clk, aligned with the updated positions.
- Between ticks, all outputs hold.
- Back-to-back frame_tick cycles are legal; each is a full frame step.
- Inputs only need to be stable in the frame_tick cycle.

## Test plan
Parameters for all scenarios: SLOTS=2, SPEED=4, COOLDOWN=3, BALL_SIZE=8, X_MAX=639, BOX_W=48, BOX_H=96.
- Reset, then fire[0]=1, facing[0]=0, spawn (100,200), one tick → slot(0,0) active at (100,200); next tick (fire=0) → x=104; p1 box far away → no pulses.
- Left edge: spawn x=6 facing left → tick2 x=2 → tick3 active=0, x=y=0, no hit. Right edge: spawn x=628 facing right → tick2 x=632 → tick3 retires.
- fire[0] held high, far targets → spawns on ticks 1 and 5. Tick 9 spawns into slot 0 only if it has retired; otherwise no spawn and a spawn happens on the first later tick with a free slot.
- Hit: P0 ball at x=196,y=200 moving right; box_x[1]=204, box_y[1]=150 → after tick x=200 overlaps → one-cycle hit[0], slot retired. Repeat with blocking[1]=1 → blocked[0] instead, hit[0]=0.
- Clash: P0 ball x=300 right, P1 ball x=310 left, same y → after tick 304/306 overlap → both retire, clash=1, no hit even with a box overlapping.
- start dropped mid-flight → all slots cleared next cycle. Reset and frame_tick asserted together → all outputs 0, no spawn.

Source files
------------

// File: rtl/projectile_pool.sv
// projectile_pool: per-player projectile slots with fire cooldown, off-screen retirement, hit/block and clash detection
module projectile_pool #(
  parameter int SLOTS = 4,
  parameter int SPEED = 4,
  parameter int COOLDOWN = 16,
  parameter int BALL_SIZE = 8,
  parameter int X_MAX = 639,
  parameter int BOX_W = 48,
  parameter int BOX_H = 96
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_tick,
  input  logic                  start,
  input  logic [1:0]            fire,
  input  logic [1:0]            facing,
  input  logic [19:0]           spawn_x,
  input  logic [19:0]           spawn_y,
  input  logic [19:0]           box_x,
  input  logic [19:0]           box_y,
  input  logic [1:0]            blocking,
  output logic [2*SLOTS*10-1:0] ball_x,
  output logic [2*SLOTS*10-1:0] ball_y,
  output logic [2*SLOTS-1:0]    ball_active,
  output logic [1:0]            hit,
  output logic [1:0]            blocked,
  output logic                  clash
);
  localparam int N = 2 * SLOTS;
  localparam int CW = $clog2(COOLDOWN + 1);
  logic [N-1:0] act, dir, act_n, dir_n, off, surv, cl, hc, sel;
  logic [9:0] x [N];
  logic [9:0] y [N];
  logic [9:0] mx [N];
  logic [9:0] x_n [N];
  logic [9:0] y_n [N];
  logic [CW-1:0] cd [2];
  logic [CW-1:0] cd_n [2];
  logic [1:0] hp, sp;
  function automatic logic ovl(input logic [9:0] a, input logic [9:0] b, input int wb);
    return ({2'b0, a} <= {2'b0, b} + 12'(wb - 1)) && ({2'b0, b} <= {2'b0, a} + 12'(BALL_SIZE - 1));
  endfunction
  always_comb begin
    for (int k = 0; k < N; k++) begin
      mx[k] = dir[k] ? x[k] - 10'(SPEED) : x[k] + 10'(SPEED);
      off[k] = act[k] & (dir[k] ? ({1'b0, x[k]} < 11'(SPEED))
                                : ({1'b0, x[k]} + 11'(SPEED) > 11'(X_MAX + 1 - BALL_SIZE)));
      surv[k] = act[k] & ~off[k];
    end
  end
  always_comb begin
    cl = '0;
    for (int i = 0; i < SLOTS; i++)
      for (int j = SLOTS; j < N; j++)
        if (surv[i] && surv[j] && ovl(mx[i], mx[j], BALL_SIZE) && ovl(y[i], y[j], BALL_SIZE)) begin
          cl[i] = 1'b1;
          cl[j] = 1'b1;
        end
  end
  always_comb begin
    hp = '0;
    for (int k = 0; k < N; k++) begin
      hc[k] = surv[k] & ~cl[k]
            & ovl(mx[k], k < SLOTS ? box_x[19:10] : box_x[9:0], BOX_W)
            & ovl(y[k], k < SLOTS ? box_y[19:10] : box_y[9:0], BOX_H);
      if (hc[k]) hp[k >= SLOTS] = 1'b1;
    end
  end
  always_comb begin
    sel = '0;
    sp = '0;
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < SLOTS; s++)
        if (fire[p] && cd[p] == '0 && !sp[p] && !act[p*SLOTS+s]) begin
          sel[p*SLOTS+s] = 1'b1;
          sp[p] = 1'b1;
        end
  end
  always_comb begin
    for (int k = 0; k < N; k++) begin
      act_n[k] = sel[k] | (surv[k] & ~cl[k] & ~hc[k]);
      dir_n[k] = sel[k] ? facing[k >= SLOTS] : dir[k];
      x_n[k] = sel[k] ? (k >= SLOTS ? spawn_x[19:10] : spawn_x[9:0]) : act_n[k] ? mx[k] : '0;
      y_n[k] = sel[k] ? (k >= SLOTS ? spawn_y[19:10] : spawn_y[9:0]) : act_n[k] ? y[k] : '0;
    end
    for (int p = 0; p < 2; p++)
      cd_n[p] = sp[p] ? CW'(COOLDOWN) : cd[p] != '0 ? cd[p] - 1'b1 : '0;
  end
  always_ff @(posedge Clk) begin
    if (Reset || !start) begin
      act <= '0;
      dir <= '0;
      x <= '{default: '0};
      y <= '{default: '0};
      cd <= '{default: '0};
      hit <= '0;
      blocked <= '0;
      clash <= 1'b0;
    end else begin
      hit <= frame_tick ? hp & ~{blocking[0], blocking[1]} : 2'b0;
      blocked <= frame_tick ? hp & {blocking[0], blocking[1]} : 2'b0;
      clash <= frame_tick & |cl;
      if (frame_tick) begin
        act <= act_n;
        dir <= dir_n;
        x <= x_n;
        y <= y_n;
        cd <= cd_n;
      end
    end
  end
  always_comb begin
    ball_x = '0;
    ball_y = '0;
    for (int k = 0; k < N; k++) begin
      ball_x[k*10 +: 10] = x[k];
      ball_y[k*10 +: 10] = y[k];
    end
  end
  assign ball_active = act;
endmodule

// File: tb/tb_projectile_pool.sv
// tb_projectile_pool: scoreboard bench for projectile_pool
module tb_projectile_pool;
  logic Clk = 1'b0;
  logic Reset, frame_tick, start;
  logic [1:0] fire, facing, blocking, hit, blocked;
  logic [19:0] spawn_x, spawn_y, box_x, box_y;
  logic [39:0] ball_x, ball_y;
  logic [3:0] ball_active;
  logic clash;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {
    string tag;
    logic [3:0] a;
    logic [39:0] x, y;
    logic [1:0] h, b;
    logic c;
  } exp_t;
  exp_t sb[$];
  projectile_pool #(.SLOTS(2), .SPEED(4), .COOLDOWN(3), .BALL_SIZE(8), .X_MAX(639), .BOX_W(48), .BOX_H(96)) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start(start), .fire(fire), .facing(facing),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .box_x(box_x), .box_y(box_y), .blocking(blocking),
    .ball_x(ball_x), .ball_y(ball_y), .ball_active(ball_active), .hit(hit), .blocked(blocked), .clash(clash)
  );
  always #5 Clk = ~Clk;
  function automatic logic [39:0] pk(input int s0, input int s1, input int s2, input int s3);
    return {10'(s3), 10'(s2), 10'(s1), 10'(s0)};
  endfunction
  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic tk, input logic [3:0] a, input logic [39:0] x,
                      input logic [39:0] y, input logic [1:0] h, input logic [1:0] b, input logic c);
    exp_t e;
    sb.push_back('{tag, a, x, y, h, b, c});
    frame_tick = tk;
    @(negedge Clk);
    frame_tick = 1'b0;
    e = sb.pop_front();
    chk({e.tag, ".act"}, 40'(ball_active), 40'(e.a));
    chk({e.tag, ".x"}, ball_x, e.x);
    chk({e.tag, ".y"}, ball_y, e.y);
    chk({e.tag, ".hit"}, 40'(hit), 40'(e.h));
    chk({e.tag, ".blocked"}, 40'(blocked), 40'(e.b));
    chk({e.tag, ".clash"}, 40'(clash), 40'(e.c));
  endtask
  task automatic clear();
    start = 1'b0;
    step("clear", 0, 0, 0, 0, 0, 0, 0);
    start = 1'b1;
  endtask
  initial begin
    Reset = 1'b1; start = 1'b0; frame_tick = 1'b0; fire = 0; facing = 0; blocking = 0;
    spawn_x = 0; spawn_y = 0; box_x = 0; box_y = 0;
    repeat (3) @(negedge Clk);
    step("reset", 0, 0, 0, 0, 0, 0, 0);
    Reset = 1'b0;
    start = 1'b1;
    fire = 2'b01; spawn_x = {10'd0, 10'd100}; spawn_y = {10'd0, 10'd200};
    step("spawn", 1, 4'b0001, pk(100, 0, 0, 0), pk(200, 0, 0, 0), 0, 0, 0);
    fire = 2'b00;
    step("move", 1, 4'b0001, pk(104, 0, 0, 0), pk(200, 0, 0, 0), 0, 0, 0);
    step("hold", 0, 4'b0001, pk(104, 0, 0, 0), pk(200, 0, 0, 0), 0, 0, 0);
    start = 1'b0;
    step("stop", 0, 0, 0, 0, 0, 0, 0);
    fire = 2'b01;
    step("stop_tick", 1, 0, 0, 0, 0, 0, 0);
    start = 1'b1;
    facing = 2'b01; spawn_x = {10'd0, 10'd6};
    step("l_spawn", 1, 4'b0001, pk(6, 0, 0, 0), pk(200, 0, 0, 0), 0, 0, 0);
    fire = 2'b00;
    step("l_move", 1, 4'b0001, pk(2, 0, 0, 0), pk(200, 0, 0, 0), 0, 0, 0);
    step("l_retire", 1, 0, 0, 0, 0, 0, 0);
    clear();
    fire = 2'b01; facing = 2'b00; spawn_x = {10'd0, 10'd628};
    step("r_spawn", 1, 4'b0001, pk(628, 0, 0, 0), pk(200, 0, 0, 0), 0, 0, 0);
    fire = 2'b00;
    step("r_move", 1, 4'b0001, pk(632, 0, 0, 0), pk(200, 0, 0, 0), 0, 0, 0);
    step("r_retire", 1, 0, 0, 0, 0, 0, 0);
    clear();
    fire = 2'b01; facing = 2'b01; spawn_x = {10'd0, 10'd32};
    for (int t = 1; t <= 4; t++)
      step($sformatf("cd_t%0d", t), 1, 4'b0001, pk(36 - 4 * t, 0, 0, 0), pk(200, 0, 0, 0), 0, 0, 0);
    for (int t = 5; t <= 9; t++)
      step($sformatf("cd_t%0d", t), 1, 4'b0011, pk(36 - 4 * t, 52 - 4 * t, 0, 0), pk(200, 200, 0, 0), 0, 0, 0);
    step("cd_t10", 1, 4'b0010, pk(0, 12, 0, 0), pk(0, 200, 0, 0), 0, 0, 0);
    step("cd_t11", 1, 4'b0011, pk(32, 8, 0, 0), pk(200, 200, 0, 0), 0, 0, 0);
    fire = 2'b00;
    clear();
    fire = 2'b01; facing = 2'b00; spawn_x = {10'd0, 10'd196};
    step("h_spawn", 1, 4'b0001, pk(196, 0, 0, 0), pk(200, 0, 0, 0), 0, 0, 0);
    fire = 2'b00; box_x = {10'd204, 10'd0}; box_y = {10'd150, 10'd0};
    step("hit", 1, 0, 0, 0, 2'b01, 2'b00, 0);
    step("hit_end", 0, 0, 0, 0, 0, 0, 0);
    clear();
    fire = 2'b01;
    step("b_spawn", 1, 4'b0001, pk(196, 0, 0, 0), pk(200, 0, 0, 0), 0, 0, 0);
    fire = 2'b00; blocking = 2'b10;
    step("blocked", 1, 0, 0, 0, 2'b00, 2'b01, 0);
    step("blk_end", 0, 0, 0, 0, 0, 0, 0);
    blocking = 2'b00; box_x = 0; box_y = 0;
    clear();
    fire = 2'b11; facing = 2'b10; spawn_x = {10'd310, 10'd300}; spawn_y = {10'd200, 10'd200};
    step("c_spawn", 1, 4'b0101, pk(300, 0, 310, 0), pk(200, 0, 200, 0), 0, 0, 0);
    fire = 2'b00; box_x = {10'd300, 10'd300}; box_y = {10'd150, 10'd150};
    step("clash", 1, 0, 0, 0, 0, 0, 1);
    step("clash_end", 0, 0, 0, 0, 0, 0, 0);
    box_x = 0; box_y = 0;
    clear();
    fire = 2'b10; spawn_x = {10'd300, 10'd0}; spawn_y = {10'd100, 10'd0};
    step("p1_spawn", 1, 4'b0100, pk(0, 0, 300, 0), pk(0, 0, 100, 0), 0, 0, 0);
    fire = 2'b00; box_x = {10'd0, 10'd250}; box_y = {10'd0, 10'd50}; blocking = 2'b01;
    step("p1_blocked", 1, 0, 0, 0, 2'b00, 2'b10, 0);
    blocking = 2'b00; box_x = 0; box_y = 0;
    clear();
    fire = 2'b01; facing = 2'b00; spawn_x = {10'd0, 10'd100}; spawn_y = {10'd0, 10'd200};
    step("rs_spawn", 1, 4'b0001, pk(100, 0, 0, 0), pk(200, 0, 0, 0), 0, 0, 0);
    Reset = 1'b1;
    step("rst_tick", 1, 0, 0, 0, 0, 0, 0);
    Reset = 1'b0; fire = 2'b00;
    step("post_rst", 0, 0, 0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
